// File: rtl/uop_xor_accum_if.sv
// Stream-in / result-out bundle for uop_xor_accum.
// UOP_XOR_ACCUM_CHECK_EN adds s_expect / m_error.
interface uop_xor_accum_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_checksum;
  logic             m_parity;
  logic [CNT_W-1:0] m_count;
  logic             m_sat;
`ifdef UOP_XOR_ACCUM_CHECK_EN
  logic [WIDTH-1:0] s_expect;
  logic             m_error;
`endif

  modport master (
`ifdef UOP_XOR_ACCUM_CHECK_EN
    output s_expect,
    input  m_error,
`endif
    output s_valid,
    input  s_ready,
    output s_data,
    output s_last,
    input  m_valid,
    output m_ready,
    input  m_checksum,
    input  m_parity,
    input  m_count,
    input  m_sat
  );

  modport slave (
`ifdef UOP_XOR_ACCUM_CHECK_EN
    input  s_expect,
    output m_error,
`endif
    input  s_valid,
    output s_ready,
    input  s_data,
    input  s_last,
    output m_valid,
    input  m_ready,
    output m_checksum,
    output m_parity,
    output m_count,
    output m_sat
  );
endinterface

// File: rtl/uop_xor_accum.sv
// Streaming XOR checksum / parity / beat-count accumulator.
// Optional UOP_XOR_ACCUM_CHECK_EN compares the checksum to s_expect.
module uop_xor_accum #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  uop_xor_accum_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_n;
  logic             run_q;
  logic             ready;
  logic             valid;
  logic             accept;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_n;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             par;

  // run_q keeps s_ready low for the whole reset and one edge past it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      run_q <= 1'b0;
    end else begin
      state <= state_n;
      run_q <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (accept && bus.s_last) state_n = HOLD;
        else if (accept)          state_n = ACCUM;
      end
      HOLD:    if (bus.m_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    valid = 1'b0;
    unique case (state)
      IDLE, ACCUM: ready = run_q;
      HOLD:        valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = bus.s_valid && ready;
  assign acc_n  = (state == IDLE) ? bus.s_data
                                  : acc ^ bus.s_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
      par <= 1'b0;
    end else if (accept) begin
      acc <= acc_n;
      par <= (^acc_n) ^ ODD_PARITY;
      if (state == IDLE) begin
        cnt <= CNT_ONE;
        sat <= 1'b0;
      end else if (cnt == CNT_MAX) begin
        sat <= 1'b1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

`ifdef UOP_XOR_ACCUM_CHECK_EN
  logic err;

  always_ff @(posedge clk) begin
    if (!rst_n)
      err <= 1'b0;
    else if (accept && bus.s_last)
      err <= (acc_n != bus.s_expect);
  end

  assign bus.m_error = err;
`endif

  assign bus.s_ready    = ready;
  assign bus.m_valid    = valid;
  assign bus.m_checksum = acc;
  assign bus.m_parity   = par;
  assign bus.m_count    = cnt;
  assign bus.m_sat      = sat;

endmodule

// File: tb/tb_uop_xor_accum.sv
// Directed bench: even-parity CNT_W=8 and odd-parity CNT_W=2
// instances driven in lockstep from one stimulus stream.
module tb_uop_xor_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_ready;
  logic [7:0] s_expect;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uop_xor_accum_if #(.WIDTH(8), .CNT_W(8)) i0 ();
  uop_xor_accum_if #(.WIDTH(8), .CNT_W(2)) i1 ();

  assign i0.s_valid = s_valid;
  assign i0.s_data  = s_data;
  assign i0.s_last  = s_last;
  assign i0.m_ready = m_ready;
  assign i1.s_valid = s_valid;
  assign i1.s_data  = s_data;
  assign i1.s_last  = s_last;
  assign i1.m_ready = m_ready;
`ifdef UOP_XOR_ACCUM_CHECK_EN
  assign i0.s_expect = s_expect;
  assign i1.s_expect = s_expect;
`endif

  uop_xor_accum #(
    .WIDTH(8), .CNT_W(8), .ODD_PARITY(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(i0.slave)
  );

  uop_xor_accum #(
    .WIDTH(8), .CNT_W(2), .ODD_PARITY(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(i1.slave)
  );

  // {m_valid, m_checksum, m_parity, m_count, m_sat}
  logic [18:0] o0;
  logic [12:0] o1;
  assign o0 = {i0.m_valid, i0.m_checksum, i0.m_parity,
               i0.m_count, i0.m_sat};
  assign o1 = {i1.m_valid, i1.m_checksum, i1.m_parity,
               i1.m_count, i1.m_sat};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h5a;
    s_last  = 1'b1;
    m_ready = 1'b1;
    s_expect = 8'h00;
    tick();
    tick();
    checks++;
    if (o0 !== 19'h0) begin
      errors++;
      $display("FAIL reset_out0 got %h exp %h", o0, 19'h0);
    end
    checks++;
    if (o1 !== 13'h0) begin
      errors++;
      $display("FAIL reset_out1 got %h exp %h", o1, 13'h0);
    end
    checks++;
    if ({i0.s_ready, i1.s_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b exp 00",
               {i0.s_ready, i1.s_ready});
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_n   = 1'b1;
    tick();
    checks++;
    if ({i0.s_ready, i1.s_ready} !== 2'b11) begin
      errors++;
      $display("FAIL post_reset_ready got %b exp 11",
               {i0.s_ready, i1.s_ready});
    end
  endtask

  task automatic test_frame();
    send(8'ha5, 1'b0);
    send(8'h3c, 1'b0);
    send(8'h0f, 1'b1);
    checks++;
    if (o0 !== {1'b1, 8'h96, 1'b0, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL frame_out0 got %h exp %h", o0,
               {1'b1, 8'h96, 1'b0, 8'd3, 1'b0});
    end
    checks++;
    if (o1 !== {1'b1, 8'h96, 1'b1, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL frame_out1 got %h exp %h", o1,
               {1'b1, 8'h96, 1'b1, 2'd3, 1'b0});
    end
    tick();
    checks++;
    if ({i0.m_valid, i1.m_valid, i0.s_ready} !== 3'b001) begin
      errors++;
      $display("FAIL frame_idle got %b exp 001",
               {i0.m_valid, i1.m_valid, i0.s_ready});
    end
  endtask

  task automatic test_single();
    send(8'hff, 1'b1);
    checks++;
    if (o0 !== {1'b1, 8'hff, 1'b0, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_out0 got %h exp %h", o0,
               {1'b1, 8'hff, 1'b0, 8'd1, 1'b0});
    end
    checks++;
    if (o1 !== {1'b1, 8'hff, 1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_out1 got %h exp %h", o1,
               {1'b1, 8'hff, 1'b1, 2'd1, 1'b0});
    end
    tick();
  endtask

  task automatic test_backpressure();
    send(8'h12, 1'b0);
    m_ready = 1'b0;
    send(8'h34, 1'b1);
    s_valid = 1'b1;
    s_data  = 8'h77;
    s_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o0 !== {1'b1, 8'h26, 1'b1, 8'd2, 1'b0} ||
          i0.s_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold0 cyc %0d got %h rdy %b exp %h",
                 i, o0, i0.s_ready,
                 {1'b1, 8'h26, 1'b1, 8'd2, 1'b0});
      end
      checks++;
      if (o1 !== {1'b1, 8'h26, 1'b0, 2'd2, 1'b0} ||
          i1.s_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold1 cyc %0d got %h rdy %b exp %h",
                 i, o1, i1.s_ready,
                 {1'b1, 8'h26, 1'b0, 2'd2, 1'b0});
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    checks++;
    if ({i0.m_valid, i0.s_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got %b exp 01",
               {i0.m_valid, i0.s_ready});
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    if (o0 !== {1'b1, 8'h77, 1'b0, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL bp_next0 got %h exp %h", o0,
               {1'b1, 8'h77, 1'b0, 8'd1, 1'b0});
    end
    checks++;
    if (o1 !== {1'b1, 8'h77, 1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL bp_next1 got %h exp %h", o1,
               {1'b1, 8'h77, 1'b1, 2'd1, 1'b0});
    end
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) send(8'h01, 1'b0);
    send(8'h01, 1'b1);
    checks++;
    if (o0 !== {1'b1, 8'h01, 1'b1, 8'd5, 1'b0}) begin
      errors++;
      $display("FAIL sat_out0 got %h exp %h", o0,
               {1'b1, 8'h01, 1'b1, 8'd5, 1'b0});
    end
    checks++;
    if (o1 !== {1'b1, 8'h01, 1'b0, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL sat_out1 got %h exp %h", o1,
               {1'b1, 8'h01, 1'b0, 2'd3, 1'b1});
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({i0.m_valid, i1.m_valid} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_valid got %b exp 00",
               {i0.m_valid, i1.m_valid});
    end
    tick();
    send(8'h05, 1'b1);
    checks++;
    if (o0 !== {1'b1, 8'h05, 1'b0, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_out0 got %h exp %h", o0,
               {1'b1, 8'h05, 1'b0, 8'd1, 1'b0});
    end
    checks++;
    if (o1 !== {1'b1, 8'h05, 1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_out1 got %h exp %h", o1,
               {1'b1, 8'h05, 1'b1, 2'd1, 1'b0});
    end
    tick();
  endtask

`ifdef UOP_XOR_ACCUM_CHECK_EN
  task automatic test_check();
    send(8'ha5, 1'b0);
    send(8'h3c, 1'b0);
    s_expect = 8'h96;
    send(8'h0f, 1'b1);
    checks++;
    if ({i0.m_valid, i0.m_error, i1.m_error} !== 3'b100) begin
      errors++;
      $display("FAIL check_match got %b exp 100",
               {i0.m_valid, i0.m_error, i1.m_error});
    end
    tick();
    send(8'ha5, 1'b0);
    send(8'h3c, 1'b0);
    s_expect = 8'h97;
    send(8'h0f, 1'b1);
    checks++;
    if ({i0.m_valid, i0.m_error, i1.m_error} !== 3'b111) begin
      errors++;
      $display("FAIL check_mismatch got %b exp 111",
               {i0.m_valid, i0.m_error, i1.m_error});
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_single();
    test_backpressure();
    test_saturation();
    test_reset_midframe();
`ifdef UOP_XOR_ACCUM_CHECK_EN
    test_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
